// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
package hazard_pkg;

    // Register specifier width carried in the shadow slots.
    localparam int unsigned STAGE_AW = 4;

    // Operand-select encodings seen by the EX-stage forwarding muxes.
    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Fields kept for every shadow slot.
    typedef struct packed {
        logic                valid;
        logic [STAGE_AW-1:0] rd;
        logic                regwrite;
    } stage_t;

    // EX slot additionally keeps its sources and the load flag.
    typedef struct packed {
        stage_t              base;
        logic [STAGE_AW-1:0] rs1;
        logic [STAGE_AW-1:0] rs2;
        logic                memread;
    } ex_slot_t;

    // A slot produces a forwardable result only for a real write to a non-zero register.
    function automatic logic writes_reg(stage_t s);
        return s.valid & s.regwrite & (s.rd != '0);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Forward select for one EX source operand against the MEM and WB shadow slots.
module fwd_select
    import hazard_pkg::*;
(
    input  logic [STAGE_AW-1:0] i_src,
    input  stage_t              i_mem,
    input  stage_t              i_wb,
    output logic [1:0]          o_sel
);

    // MEM is checked first: the younger result wins when both slots match.
    always_comb begin
        o_sel = FWD_IDEX;
        if (writes_reg(i_mem) && (i_mem.rd == i_src)) begin
            o_sel = FWD_EXMEM;
        end else if (writes_reg(i_wb) && (i_wb.rd == i_src)) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Shadow EX/MEM/WB tracking, operand forwarding selects, load-use and branch
// pipeline control, and saturating stall/flush counters.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    // Must equal hazard_pkg::STAGE_AW; the shadow slots are sized from the package.
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              branch_taken,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall,
    output logic              bubble,
    output logic              flush_ifid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ex_slot_t         r_ex;
    stage_t           r_mem;
    stage_t           r_wb;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    ex_slot_t         w_ex_d;
    logic             w_hazard;

    // Load in EX whose destination is a source of the instruction in ID.
    always_comb begin
        w_hazard = id_valid & r_ex.base.valid & r_ex.memread & (r_ex.base.rd != '0) &
                   ((r_ex.base.rd == id_rs1) | (r_ex.base.rd == id_rs2));
    end

    // Pipeline controls; a taken branch overrides the load-use stall.
    always_comb begin
        flush_ifid = branch_taken;
        bubble     = branch_taken | w_hazard;
        stall      = w_hazard & ~branch_taken;
    end

    // Next EX slot: nops are stored fully zeroed so stale specifiers never match.
    always_comb begin
        w_ex_d = '0;
        if (!bubble && id_valid) begin
            w_ex_d.base.valid    = 1'b1;
            w_ex_d.base.rd       = id_rd;
            w_ex_d.base.regwrite = id_regwrite;
            w_ex_d.rs1           = id_rs1;
            w_ex_d.rs2           = id_rs2;
            w_ex_d.memread       = id_memread;
        end
    end

    // Shadow pipeline advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_ex  <= w_ex_d;
            r_mem <= r_ex.base;
            r_wb  <= r_mem;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush_ifid && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    fwd_select u_fwd_a (
        .i_src (r_ex.rs1),
        .i_mem (r_mem),
        .i_wb  (r_wb),
        .o_sel (forward_a)
    );

    fwd_select u_fwd_b (
        .i_src (r_ex.rs2),
        .i_mem (r_mem),
        .i_wb  (r_wb),
        .o_sel (forward_b)
    );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit. Counters are narrowed to 5 bits so
// saturation at all-ones is reachable in a short run.
module tb_hazard_forward_unit;

    localparam int AW = 4;
    localparam int CW = 5;

    typedef struct packed {
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          st;
        logic          bu;
        logic          fl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } obs_t;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
        logic          br;
        obs_t          e;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0;
    logic [AW-1:0] id_rs2 = '0;
    logic [AW-1:0] id_rd = '0;
    logic          id_regwrite = 1'b0;
    logic          id_memread = 1'b0;
    logic          branch_taken = 1'b0;
    logic [1:0]    forward_a;
    logic [1:0]    forward_b;
    logic          stall;
    logic          bubble;
    logic          flush_ifid;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    int    n_checks = 0;
    int    n_fail = 0;
    stim_t stim_q[$];
    obs_t  sb[$];

    hazard_forward_unit #(
        .REG_AW (AW),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .branch_taken (branch_taken),
        .forward_a    (forward_a),
        .forward_b    (forward_b),
        .stall        (stall),
        .bubble       (bubble),
        .flush_ifid   (flush_ifid),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.fa = forward_a;
        o.fb = forward_b;
        o.st = stall;
        o.bu = bubble;
        o.fl = flush_ifid;
        o.sc = stall_cnt;
        o.fc = flush_cnt;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("fa=%b fb=%b stall=%b bubble=%b flush=%b stall_cnt=%0d flush_cnt=%0d",
                         o.fa, o.fb, o.st, o.bu, o.fl, o.sc, o.fc);
    endfunction

    // One cycle of ID/branch stimulus together with the outputs expected that cycle.
    task automatic row(input logic v, input int rs1, input int rs2, input int rd,
                       input logic rw, input logic mr, input logic br,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic st, input logic bu, input logic fl,
                       input int sc, input int fc);
        stim_t s;
        s.v    = v;
        s.rs1  = AW'(rs1);
        s.rs2  = AW'(rs2);
        s.rd   = AW'(rd);
        s.rw   = rw;
        s.mr   = mr;
        s.br   = br;
        s.e.fa = fa;
        s.e.fb = fb;
        s.e.st = st;
        s.e.bu = bu;
        s.e.fl = fl;
        s.e.sc = CW'(sc);
        s.e.fc = CW'(fc);
        stim_q.push_back(s);
    endtask

    task automatic apply(input stim_t s);
        id_valid     = s.v;
        id_rs1       = s.rs1;
        id_rs2       = s.rs2;
        id_rd        = s.rd;
        id_regwrite  = s.rw;
        id_memread   = s.mr;
        branch_taken = s.br;
        sb.push_back(s.e);
    endtask

    task automatic idle_inputs();
        id_valid     = 1'b0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_rd        = '0;
        id_regwrite  = 1'b0;
        id_memread   = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t  e;
        obs_t  o;
        stim_t s;
        // Branch and a would-be load-use in ID while held in reset.
        s = '0;
        s.v = 1'b1; s.rs1 = 4'd5; s.rd = 4'd5; s.rw = 1'b1; s.mr = 1'b1; s.br = 1'b1;
        s.e = '0; s.e.bu = 1'b1; s.e.fl = 1'b1;
        rst = 1'b1;
        apply(s);
        @(negedge clk);
        e = sb.pop_front(); o = observe(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_live: got %s, want %s", fmt(o), fmt(e));
        end
        @(posedge clk);
        #1;
        s.br = 1'b0; s.mr = 1'b0; s.rd = 4'd6;
        s.e = '0;
        apply(s);
        @(negedge clk);
        e = sb.pop_front(); o = observe(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_hold: got %s, want %s", fmt(o), fmt(e));
        end
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_forward_dist1();
        obs_t  e;
        obs_t  o;
        int    i = 0;
        do_reset();
        row(1, 1, 2, 3, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // ADD r3,r1,r2
        row(1, 3, 7, 4, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // SUB r4,r3,r7
        row(0, 0, 0, 0, 0, 0, 0,  2'b10, 2'b00, 0, 0, 0, 0, 0); // SUB in EX
        row(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0);
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = sb.pop_front(); o = observe(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL dist1 step%0d: got %s, want %s", i, fmt(o), fmt(e));
            end
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic test_forward_dist2();
        obs_t  e;
        obs_t  o;
        int    i = 0;
        do_reset();
        row(1, 1, 2, 3, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // ADD r3
        row(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // NOP
        row(1, 8, 3, 6, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // use r3 in rs2
        row(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b01, 0, 0, 0, 0, 0); // use in EX, ADD in WB
        row(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0);
        // Back-to-back writers of r3: MEM result must win over WB.
        row(1, 1, 2, 3, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0);
        row(1, 4, 5, 3, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0);
        row(1, 9, 3, 6, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b10, 0, 0, 0, 0, 0);
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = sb.pop_front(); o = observe(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL dist2 step%0d: got %s, want %s", i, fmt(o), fmt(e));
            end
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic test_load_use();
        obs_t  e;
        obs_t  o;
        int    i = 0;
        do_reset();
        row(1, 2, 0, 5, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // LD r5
        row(1, 5, 1, 6, 1, 0, 0,  2'b00, 2'b00, 1, 1, 0, 0, 0); // ADD r6,r5,r1: stall
        row(1, 5, 1, 6, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 0); // held, bubble in EX
        row(0, 0, 0, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0, 0, 1, 0); // ADD in EX, LD in WB
        row(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 0);
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = sb.pop_front(); o = observe(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL load_use step%0d: got %s, want %s", i, fmt(o), fmt(e));
            end
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic test_branch_priority();
        obs_t  e;
        obs_t  o;
        int    i = 0;
        do_reset();
        row(1, 0, 0, 5, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // LD r5
        row(1, 5, 1, 6, 1, 0, 1,  2'b00, 2'b00, 0, 1, 1, 0, 0); // hazard + taken branch
        row(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 1);
        row(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 1);
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = sb.pop_front(); o = observe(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL branch step%0d: got %s, want %s", i, fmt(o), fmt(e));
            end
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic test_r0();
        obs_t  e;
        obs_t  o;
        int    i = 0;
        do_reset();
        row(1, 1, 2, 0, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // LD r0
        row(1, 0, 0, 7, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // read r0 twice
        row(1, 0, 0, 0, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0); // write r0, LD r0 in MEM
        row(1, 0, 0, 8, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0);
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = sb.pop_front(); o = observe(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL r0 step%0d: got %s, want %s", i, fmt(o), fmt(e));
            end
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    // A constant "LD r5,(r5)" in ID stalls every other cycle.
    task automatic test_saturation();
        obs_t  e;
        obs_t  o;
        int    i = 0;
        int    sc;
        do_reset();
        for (int k = 0; k < 70; k++) begin
            sc = (k / 2 > 31) ? 31 : k / 2;
            row(1, 5, 0, 5, 1, 1, 0,
                ((k % 2 == 1) && (k >= 3)) ? 2'b01 : 2'b00, 2'b00,
                logic'(k % 2), logic'(k % 2), 0, sc, 0);
        end
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = sb.pop_front(); o = observe(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL saturate step%0d: got %s, want %s", i, fmt(o), fmt(e));
            end
            @(posedge clk);
            #1;
            i++;
        end
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (stall_cnt !== {CW{1'b1}}) begin
            n_fail++;
            $display("FAIL saturate_final: stall_cnt=%0d want %0d", stall_cnt, {CW{1'b1}});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        obs_t  e;
        obs_t  o;
        int    i = 0;
        do_reset();
        row(0, 0, 0, 0, 0, 0, 1,  2'b00, 2'b00, 0, 1, 1, 0, 0); // taken branch
        row(1, 0, 0, 5, 1, 1, 0,  2'b00, 2'b00, 0, 0, 0, 0, 1); // LD r5
        row(1, 5, 0, 3, 1, 0, 0,  2'b00, 2'b00, 1, 1, 0, 0, 1); // ADD r3,r5: stall
        row(1, 5, 0, 3, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 1);
        row(1, 3, 0, 4, 1, 0, 0,  2'b01, 2'b00, 0, 0, 0, 1, 1); // ADD in EX
        row(0, 0, 0, 0, 0, 0, 0,  2'b10, 2'b00, 0, 0, 0, 1, 1); // SUB in EX, dist 1
        while (stim_q.size() != 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            e = sb.pop_front(); o = observe(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid step%0d: got %s, want %s", i, fmt(o), fmt(e));
            end
            if (stim_q.size() != 0) begin
                @(posedge clk);
                #1;
            end
            i++;
        end
        // Reset between clock edges must clear selects and counters immediately.
        #2;
        rst = 1'b1;
        sb.push_back('0);
        #1;
        e = sb.pop_front(); o = observe(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_async: got %s, want %s", fmt(o), fmt(e));
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_forward_dist1();
        test_forward_dist2();
        test_load_use();
        test_branch_priority();
        test_r0();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Tracks the destination registers of instructions in EX, MEM and WB, and produces the `forward_a`/`forward_b` selects consumed by the EX-stage operand forwarding muxes. It also detects load-use hazards and branch flushes, and drives the pipeline stall, bubble and flush controls. It sits beside the ID/EX pipeline register in the 16-bit datapath. It keeps its own shadow copy of stage state, so it needs no taps into the datapath pipeline registers.

## Interface
Parameters:
- `REG_AW`, 4: register specifier width (16 architectural registers; r0 reads as zero).
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  REG_AW  source specifiers of the instruction in ID.
- `id_rd`  in  REG_AW  destination specifier of the instruction in ID.
- `id_regwrite`  in  1  the ID instruction writes `id_rd`.
- `id_memread`  in  1  the ID instruction is a load.
- `branch_taken`  in  1  the branch in EX resolved taken this cycle.
- `forward_a`, `forward_b`  out  2  operand selects: 00 = ID/EX value, 10 = EX/MEM result, 01 = MEM/WB result.
- `stall`  out  1  hold the PC and IF/ID.
- `bubble`  out  1  zero the control fields entering ID/EX.
- `flush_ifid`  out  1  invalidate IF/ID.
- `stall_cnt`  out  CNT_W  load-use stall cycles, saturating.
- `flush_cnt`  out  CNT_W  taken-branch flushes, saturating.

## Operation
**Shadow pipeline**
- EX slot fields: valid, rs1, rs2, rd, regwrite, memread.
- MEM and WB slot fields: valid, rd, regwrite.
- Each cycle: WB ← MEM, MEM ← EX.
- EX ← ID fields, or a nop (valid=0) when `bubble`=1.

**Forwarding** (combinational from shadow state):
- `forward_a` = 10 if MEM.valid & MEM.regwrite & MEM.rd≠0 & MEM.rd==EX.rs1.
- Otherwise `forward_a` = 01 if the same test passes against WB.
- Otherwise `forward_a` = 00.
- `forward_b` is computed identically, using EX.rs2.
- When both MEM and WB match, EX/MEM wins (younger result).

**Load-use hazard:**
- hazard = id_valid & EX.valid & EX.memread & EX.rd≠0 & (EX.rd==id_rs1 | EX.rd==id_rs2).
- On a hazard: `stall`=1 and `bubble`=1, for exactly one cycle per hazard.
- The next cycle the load sits in MEM, the hazard clears, and the forward from MEM/WB is used one cycle later.

**Branch:**
- `branch_taken`=1 forces `flush_ifid`=1 and `bubble`=1, and forces `stall`=0.
- A taken branch has priority over a simultaneous hazard.

**Counters:**
- `stall_cnt` increments on each cycle with `stall`=1.
- `flush_cnt` increments on each cycle with `flush_ifid`=1.
- Both saturate at all-ones and never wrap.

A source specifier of r0 never forwards and never stalls.

## Timing
- Reset values: all shadow valid bits 0, `stall_cnt`=`flush_cnt`=0.
- Consequently, during and right after reset, `forward_a`=`forward_b`=00 and `stall`=`bubble`=`flush_ifid`=0 (the hazard/branch outputs still depend on live inputs).
- Forward selects are valid in the same cycle the consumer is in EX: zero added latency, combinational from registered state.
- `stall`, `bubble` and `flush_ifid` are combinational from the ID inputs, `branch_taken` and the EX shadow. The pipeline samples them at the next rising edge.
- Producer-to-consumer distance and the resulting select:
  - Distance 1 → 10.
  - Distance 2 → 01.
  - Distance 3 or more → 00 (the register file handles write-before-read).
- Reset asserted mid-operation clears all shadow state and counters immediately (asynchronously). No forward or stall survives reset.

## Structure
- Shared package `hazard_pkg`:
  - constants `FWD_IDEX`=2'b00, `FWD_EXMEM`=2'b10, `FWD_MEMWB`=2'b01;
  - typedef `stage_t` holding the valid/rd/regwrite fields used for the shadow slots.
- Sub-module `fwd_select`: combinational compare of one source specifier against the MEM and WB slots, returning a 2-bit select. Instantiated twice, once for A and once for B.
- The top level holds the shadow registers, the hazard/branch logic and the counters.

## Test plan
- **ADD r3 then SUB using r3 in rs1** (distance 1): when SUB is in EX, `forward_a`=10 and `forward_b`=00.
- **ADD r3, NOP, then use of r3 in rs2** (distance 2): `forward_b`=01. In the back-to-back case where both MEM and WB write r3, `forward_b`=10.
- **LD r5 followed directly by ADD r6,r5,r1**: one cycle of `stall`=`bubble`=1 and `stall_cnt`=1. Then, with ADD in EX, `forward_a`=01.
- **`branch_taken`=1 with a concurrent ID load-use match**: `flush_ifid`=1, `bubble`=1, `stall`=0, `flush_cnt` increments, `stall_cnt` unchanged.
- **Write to r0 followed by a read of r0**: selects stay 00 and `stall` stays 0. Separately, preload `stall_cnt` near saturation via repeated hazards and confirm it holds at 0xFFFF.
- **Assert `rst` mid-sequence** while a distance-1 forward is active: selects go to 00 and the counters to 0 without waiting for a clock edge.
